// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing: registered counters, syncs, blanking and start strobes.
// Define VGA_SYNC_FRAME_CNT_EN to build the completed-frame counter on frame_cnt.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_NEG  = 1,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_INV   = (SYNC_NEG != 0);

  logic [9:0] r_hpos, r_vpos;
  logic       r_hsync, r_vsync, r_display_on, r_line_start, r_frame_start;
  logic [9:0] w_h_next, w_v_next;
  logic       w_h_wrap, w_v_wrap;

  always_comb begin
    w_h_wrap = (r_hpos == H_MAX);
    w_v_wrap = (r_vpos == V_MAX);
    w_h_next = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
    w_v_next = r_vpos;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? 10'd0 : r_vpos + 10'd1;
    end
  end

  // Flags are derived from the next counter values so they line up with hpos/vpos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hpos        <= H_MAX;
      r_vpos        <= V_MAX;
      r_hsync       <= SYNC_INV;
      r_vsync       <= SYNC_INV;
      r_display_on  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_hpos        <= w_h_next;
      r_vpos        <= w_v_next;
      r_hsync       <= ((w_h_next >= H_SYNC_BEG) && (w_h_next <= H_SYNC_END)) ^ SYNC_INV;
      r_vsync       <= ((w_v_next >= V_SYNC_BEG) && (w_v_next <= V_SYNC_END)) ^ SYNC_INV;
      r_display_on  <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
      r_line_start  <= (w_h_next == 10'd0);
      r_frame_start <= (w_h_next == 10'd0) && (w_v_next == 10'd0);
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic               r_run;
  logic [FRAME_W-1:0] r_frame_cnt;

  // r_run masks the reset-state wrap so the first edge is not counted as a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_frame_cnt <= '0;
    end else if (ce) begin
      r_run <= 1'b1;
      if (r_run && w_h_wrap && w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line/ce/reset checks, reduced-timing
// instance (active-high syncs, 2-bit frame counter) for whole-frame checks.
module tb_vga_sync_gen;

  logic       clk;
  logic       rst_n;
  logic       ce;

  logic [9:0] hpos, vpos;
  logic       hsync, vsync, display_on, line_start, frame_start;
  logic [7:0] frame_cnt;

  logic [9:0] s_hpos, s_vpos;
  logic       s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
  logic [1:0] s_frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  vga_sync_gen u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .hpos        (hpos),
    .vpos        (vpos),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  // H_TOTAL=15 (sync 10..12), V_TOTAL=13 (sync 8..9), 195 cycles per frame.
  vga_sync_gen #(
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (2),
    .V_DISPLAY (6),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3),
    .SYNC_NEG  (0),
    .FRAME_W   (2)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .display_on  (s_display_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .frame_cnt   (s_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_low;
    int h, v, fexp;

    rst_n = 1'b0;
    ce    = 1'b1;
    repeat (3) step();

    check("rst_hpos", 32'(hpos), 32'd799);
    check("rst_vpos", 32'(vpos), 32'd524);
    check("rst_disp", 32'(display_on), 32'd0);
    check("rst_ls", 32'(line_start), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_hs", 32'(hsync), 32'd1);
    check("rst_vs", 32'(vsync), 32'd1);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_s_hs", 32'(s_hsync), 32'd0);
    check("rst_s_vs", 32'(s_vsync), 32'd0);

    rst_n = 1'b1;
    step();
    check("first_hpos", 32'(hpos), 32'd0);
    check("first_vpos", 32'(vpos), 32'd0);
    check("first_disp", 32'(display_on), 32'd1);
    check("first_ls", 32'(line_start), 32'd1);
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_hs", 32'(hsync), 32'd1);
    check("first_vs", 32'(vsync), 32'd1);
    check("first_fcnt", 32'(frame_cnt), 32'd0);

    hs_low = 0;
    for (int i = 1; i < 800; i++) begin
      step();
      check($sformatf("line_hpos@%0d", i), 32'(hpos), 32'(i));
      check($sformatf("line_vpos@%0d", i), 32'(vpos), 32'd0);
      check($sformatf("line_disp@%0d", i), 32'(display_on), 32'(i < 640));
      check($sformatf("line_hs@%0d", i), 32'(hsync), 32'(!(i >= 656 && i <= 751)));
      check($sformatf("line_ls@%0d", i), 32'(line_start), 32'd0);
      if (hsync === 1'b0) hs_low++;
    end
    check("hs_low_cycles", 32'(hs_low), 32'd96);

    step();
    check("wrap_hpos", 32'(hpos), 32'd0);
    check("wrap_vpos", 32'(vpos), 32'd1);
    check("wrap_ls", 32'(line_start), 32'd1);
    check("wrap_fs", 32'(frame_start), 32'd0);
    check("wrap_disp", 32'(display_on), 32'd1);

    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("hold_hpos%0d", i), 32'(hpos), 32'd0);
      check($sformatf("hold_vpos%0d", i), 32'(vpos), 32'd1);
      check($sformatf("hold_ls%0d", i), 32'(line_start), 32'd1);
      check($sformatf("hold_disp%0d", i), 32'(display_on), 32'd1);
    end
    ce = 1'b1;
    step();
    check("resume_hpos", 32'(hpos), 32'd1);
    check("resume_vpos", 32'(vpos), 32'd1);
    check("resume_ls", 32'(line_start), 32'd0);

    repeat (299) step();
    check("pre_rst_hpos", 32'(hpos), 32'd300);
    check("pre_rst_vpos", 32'(vpos), 32'd1);

    // Asynchronous assertion: no clock edge between driving rst_n and sampling.
    rst_n = 1'b0;
    #1;
    check("async_hpos", 32'(hpos), 32'd799);
    check("async_vpos", 32'(vpos), 32'd524);
    check("async_disp", 32'(display_on), 32'd0);
    check("async_hs", 32'(hsync), 32'd1);
    check("async_s_hpos", 32'(s_hpos), 32'd14);
    check("async_s_vpos", 32'(s_vpos), 32'd12);
    step();
    check("held_hpos", 32'(hpos), 32'd799);
    rst_n = 1'b1;

    for (int k = 0; k <= 4 * 195; k++) begin
      step();
      h = k % 15;
      v = (k / 15) % 13;
`ifdef VGA_SYNC_FRAME_CNT_EN
      fexp = (k / 195) % 4;
`else
      fexp = 0;
`endif
      check($sformatf("f_hpos@%0d", k), 32'(hpos), 32'(k));
      check($sformatf("f_vpos@%0d", k), 32'(vpos), 32'd0);
      check($sformatf("f_fs@%0d", k), 32'(frame_start), 32'(k == 0));
      check($sformatf("s_hpos@%0d", k), 32'(s_hpos), 32'(h));
      check($sformatf("s_vpos@%0d", k), 32'(s_vpos), 32'(v));
      check($sformatf("s_hs@%0d", k), 32'(s_hsync), 32'(h >= 10 && h <= 12));
      check($sformatf("s_vs@%0d", k), 32'(s_vsync), 32'(v >= 8 && v <= 9));
      check($sformatf("s_disp@%0d", k), 32'(s_display_on), 32'(h < 8 && v < 6));
      check($sformatf("s_ls@%0d", k), 32'(s_line_start), 32'(h == 0));
      check($sformatf("s_fs@%0d", k), 32'(s_frame_start), 32'(h == 0 && v == 0));
      check($sformatf("s_fcnt@%0d", k), 32'(s_frame_cnt), 32'(fexp));
    end
    check("end_fcnt", 32'(frame_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
